// File: rtl/note_pkg.sv
// Shared types for the falling-note engine: signed screen coordinate, slot record,
// and the hit-window test used by each lane.
package note_pkg;

  typedef logic signed [12:0] coord_t;

  typedef struct packed {
    logic   active;
    coord_t y;
  } slot_t;

  // True when the note whose top is at y has its bottom edge within the hit window.
  function automatic logic in_window(coord_t y, int note_h, int hit_y, int hit_win);
    int bottom;
    bottom = int'(y) + note_h;
    return (bottom >= hit_y - hit_win) && (bottom <= hit_y + hit_win);
  endfunction

endpackage

// File: rtl/note_lane.sv
// One lane of the note engine: slot array, lowest-free allocation, scrolling,
// hit/miss judgement and the per-lane "pixel is inside a note" flag.
module note_lane
  import note_pkg::*;
#(
  parameter int SLOTS   = 4,
  parameter int X0      = 80,
  parameter int LANE_W  = 100,
  parameter int NOTE_H  = 40,
  parameter int SPAWN_Y = -40,
  parameter int HIT_Y   = 450,
  parameter int HIT_WIN = 20,
  parameter int SPEED   = 2
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   i_tick,
  input  logic   i_spawn,
  input  logic   i_key_rise,
  input  coord_t i_h,
  input  coord_t i_v,
  output logic   o_free,
  output logic   o_hit,
  output logic   o_miss,
  output logic   o_pix
);

  slot_t            r_slot [SLOTS];
  logic             r_hit, r_miss;
  logic [SLOTS-1:0] w_alloc, w_hit_sel, w_miss_sel;
  logic             w_found_free, w_found_hit, w_in_x, w_in_y;

  // Select spawn slot, hit slot and missed slots from start-of-cycle state.
  always_comb begin
    w_alloc      = '0;
    w_hit_sel    = '0;
    w_miss_sel   = '0;
    w_found_free = 1'b0;
    w_found_hit  = 1'b0;
    w_in_y       = 1'b0;
    w_in_x       = (int'(i_h) >= X0) && (int'(i_h) < X0 + LANE_W);
    for (int s = 0; s < SLOTS; s++) begin
      if (!r_slot[s].active && !w_found_free) begin
        w_alloc[s]   = 1'b1;
        w_found_free = 1'b1;
      end
      // Hits are judged on the pre-scroll position.
      if (i_key_rise && r_slot[s].active && !w_found_hit &&
          in_window(r_slot[s].y, NOTE_H, HIT_Y, HIT_WIN)) begin
        w_hit_sel[s] = 1'b1;
        w_found_hit  = 1'b1;
      end
      // A note that scrolls past the window is missed, unless it is being hit now.
      if (i_tick && r_slot[s].active && !w_hit_sel[s] &&
          (int'(r_slot[s].y) + SPEED + NOTE_H > HIT_Y + HIT_WIN))
        w_miss_sel[s] = 1'b1;
      if (r_slot[s].active && (int'(i_v) >= int'(r_slot[s].y)) &&
          (int'(i_v) < int'(r_slot[s].y) + NOTE_H))
        w_in_y = 1'b1;
    end
  end

  assign o_free = w_found_free;
  assign o_pix  = w_in_x && w_in_y;
  assign o_hit  = r_hit;
  assign o_miss = r_miss;

  // Slot update: free on hit/miss, scroll on tick, allocate on spawn; register pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < SLOTS; s++) r_slot[s] <= '0;
      r_hit  <= 1'b0;
      r_miss <= 1'b0;
    end else begin
      r_hit  <= |w_hit_sel;
      r_miss <= |w_miss_sel;
      for (int s = 0; s < SLOTS; s++) begin
        if (w_hit_sel[s] || w_miss_sel[s]) begin
          r_slot[s].active <= 1'b0;
        end else if (r_slot[s].active && i_tick) begin
          r_slot[s].y <= r_slot[s].y + coord_t'(SPEED);
        end else if (i_spawn && w_alloc[s]) begin
          r_slot[s].active <= 1'b1;
          r_slot[s].y      <= coord_t'(SPAWN_Y);
        end
      end
    end
  end

endmodule

// File: rtl/note_lane_renderer.sv
// Falling-note engine plus VGA overlay: owns the scroll tick, key edge detection,
// the spawn handshake and the one-cycle pixel compositing register.
module note_lane_renderer
  import note_pkg::*;
#(
  parameter int LANES      = 4,
  parameter int SLOTS      = 4,
  parameter int LANE_X0    = 80,
  parameter int LANE_PITCH = 120,
  parameter int LANE_W     = 100,
  parameter int NOTE_H     = 40,
  parameter int SPAWN_Y    = -40,
  parameter int HIT_Y      = 450,
  parameter int HIT_WIN    = 20,
  parameter int SPEED      = 2,
  parameter int SCROLL_DIV = 16
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic signed [12:0]                   H_cont,
  input  logic signed [12:0]                   V_cont,
  input  logic [7:0]                           iRed,
  input  logic [7:0]                           iGreen,
  input  logic [7:0]                           iBlue,
  input  logic                                 spawn_valid,
  input  logic [$clog2(LANES > 1 ? LANES : 2)-1:0] spawn_lane,
  output logic                                 spawn_ready,
  input  logic [LANES-1:0]                     key,
  output logic [LANES-1:0]                     hit_mask,
  output logic [LANES-1:0]                     miss_mask,
  output logic [7:0]                           oVGA_R,
  output logic [7:0]                           oVGA_G,
  output logic [7:0]                           oVGA_B
);

  logic [SCROLL_DIV-1:0] r_tick_cnt;
  logic [LANES-1:0]      r_key_q;
  logic [7:0]            r_r, r_g, r_b;
  logic                  w_tick;
  logic [LANES-1:0]      w_key_rise, w_free, w_spawn, w_hit, w_miss, w_pix;

  assign w_tick     = &r_tick_cnt;
  assign w_key_rise = key & ~r_key_q;

  // Free-running scroll divider and key history.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_tick_cnt <= '0;
      r_key_q    <= '0;
    end else begin
      r_tick_cnt <= r_tick_cnt + SCROLL_DIV'(1);
      r_key_q    <= key;
    end
  end

  // Ready reflects the addressed lane; out-of-range lanes are never ready.
  always_comb begin
    spawn_ready = 1'b0;
    w_spawn     = '0;
    for (int i = 0; i < LANES; i++)
      if (int'(spawn_lane) == i) spawn_ready = w_free[i];
    for (int i = 0; i < LANES; i++)
      w_spawn[i] = spawn_valid && spawn_ready && (int'(spawn_lane) == i);
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    note_lane #(
      .SLOTS  (SLOTS),
      .X0     (LANE_X0 + i * LANE_PITCH),
      .LANE_W (LANE_W),
      .NOTE_H (NOTE_H),
      .SPAWN_Y(SPAWN_Y),
      .HIT_Y  (HIT_Y),
      .HIT_WIN(HIT_WIN),
      .SPEED  (SPEED)
    ) u_lane (
      .clk       (clk),
      .reset     (reset),
      .i_tick    (w_tick),
      .i_spawn   (w_spawn[i]),
      .i_key_rise(w_key_rise[i]),
      .i_h       (H_cont),
      .i_v       (V_cont),
      .o_free    (w_free[i]),
      .o_hit     (w_hit[i]),
      .o_miss    (w_miss[i]),
      .o_pix     (w_pix[i])
    );
  end

  assign hit_mask  = w_hit;
  assign miss_mask = w_miss;

  // Composite: notes over hit line over background, one cycle of latency.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_r <= '0;
      r_g <= '0;
      r_b <= '0;
    end else if (|w_pix) begin
      r_r <= 8'd255;
      r_g <= 8'd255;
      r_b <= 8'd255;
    end else if (V_cont == coord_t'(HIT_Y)) begin
      r_r <= 8'd255;
      r_g <= 8'd0;
      r_b <= 8'd0;
    end else begin
      r_r <= iRed;
      r_g <= iGreen;
      r_b <= iBlue;
    end
  end

  assign oVGA_R = r_r;
  assign oVGA_G = r_g;
  assign oVGA_B = r_b;

endmodule

// File: tb/tb_note_lane_renderer.sv
// Scoreboard bench: the driver steps a behavioural model of the note field each cycle
// and queues the expected outputs; the monitor pops and compares one cycle later.
module tb_note_lane_renderer;
  import note_pkg::*;

  localparam int L = 4;
  localparam int S = 4;

  logic               clk = 1'b0;
  logic               reset;
  logic signed [12:0] H_cont, V_cont;
  logic [7:0]         iRed, iGreen, iBlue;
  logic               spawn_valid;
  logic [1:0]         spawn_lane;
  logic               spawn_ready;
  logic [3:0]         key, hit_mask, miss_mask;
  logic [7:0]         oVGA_R, oVGA_G, oVGA_B;

  always #5 clk = ~clk;

  note_lane_renderer #(.SCROLL_DIV(2)) dut (
    .clk(clk), .reset(reset), .H_cont(H_cont), .V_cont(V_cont),
    .iRed(iRed), .iGreen(iGreen), .iBlue(iBlue),
    .spawn_valid(spawn_valid), .spawn_lane(spawn_lane), .spawn_ready(spawn_ready),
    .key(key), .hit_mask(hit_mask), .miss_mask(miss_mask),
    .oVGA_R(oVGA_R), .oVGA_G(oVGA_G), .oVGA_B(oVGA_B)
  );

  typedef struct packed {
    logic [23:0] rgb;
    logic [3:0]  hit;
    logic [3:0]  miss;
  } exp_t;

  exp_t expq[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Model: note tops per lane/slot, cycle count since reset, previous keys.
  bit       mact[L][S];
  int       my[L][S];
  logic [3:0] mkey_q;
  int       cyc;

  task automatic model_step(output exp_t e, output bit rdy);
    bit white, tick, any_free;
    bit pre_free[L][S];
    logic [3:0] rise;
    int h, v, ln, hs, d;
    e   = '0;
    rdy = 1'b0;
    if (reset) begin
      for (int a = 0; a < L; a++) for (int b = 0; b < S; b++) mact[a][b] = 1'b0;
      mkey_q = '0;
      cyc    = 0;
      return;
    end
    h = int'(H_cont);
    v = int'(V_cont);
    rise   = key & ~mkey_q;
    mkey_q = key;
    tick   = (cyc % 4) == 3;
    cyc++;
    white = 1'b0;
    for (int a = 0; a < L; a++)
      for (int b = 0; b < S; b++)
        if (mact[a][b] && h >= 80 + a*120 && h < 180 + a*120 && v >= my[a][b] && v < my[a][b] + 40)
          white = 1'b1;
    if (white)        e.rgb = 24'hFFFFFF;
    else if (v == 450) e.rgb = 24'hFF0000;
    else              e.rgb = {iRed, iGreen, iBlue};
    for (int a = 0; a < L; a++) for (int b = 0; b < S; b++) pre_free[a][b] = !mact[a][b];
    ln = int'(spawn_lane);
    any_free = 1'b0;
    for (int b = 0; b < S; b++) if (pre_free[ln][b]) any_free = 1'b1;
    rdy = any_free;
    for (int a = 0; a < L; a++) begin
      hs = -1;
      if (rise[a])
        for (int b = 0; b < S; b++) begin
          d = my[a][b] + 40 - 450;
          if (d < 0) d = -d;
          if (hs < 0 && mact[a][b] && d <= 20) hs = b;
        end
      for (int b = 0; b < S; b++) begin
        if (!mact[a][b]) continue;
        if (b == hs) begin
          mact[a][b] = 1'b0;
          e.hit[a]   = 1'b1;
        end else if (tick && my[a][b] + 2 + 40 > 470) begin
          mact[a][b] = 1'b0;
          e.miss[a]  = 1'b1;
        end else if (tick) begin
          my[a][b] += 2;
        end
      end
    end
    if (spawn_valid && rdy)
      for (int b = 0; b < S; b++)
        if (pre_free[ln][b]) begin
          mact[ln][b] = 1'b1;
          my[ln][b]   = -40;
          break;
        end
  endtask

  // One clock: model the cycle, check the combinational ready, queue the rest.
  task automatic cyc1();
    exp_t e;
    bit   r;
    model_step(e, r);
    #1;
    if (!reset) begin
      n_tests++;
      if (spawn_ready !== r) begin
        n_fail++;
        $display("FAIL spawn_ready lane=%0d got %b exp %b at %0t", spawn_lane, spawn_ready, r, $time);
      end
    end
    expq.push_back(e);
    @(negedge clk);
  endtask

  int ph[4] = '{330, 330, 10, 200};
  int pv[4] = '{420, 450, 450, 300};

  task automatic probe(input int k);
    H_cont = 13'(ph[k % 4]);
    V_cont = 13'(pv[k % 4]);
    iRed   = 8'($urandom);
    iGreen = 8'($urandom);
    iBlue  = 8'($urandom);
  endtask

  // Monitor: compare registered outputs just after each active edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        n_tests += 3;
        if ({oVGA_R, oVGA_G, oVGA_B} !== e.rgb) begin
          n_fail++;
          $display("FAIL rgb got %06h exp %06h at %0t", {oVGA_R, oVGA_G, oVGA_B}, e.rgb, $time);
        end
        if (hit_mask !== e.hit) begin
          n_fail++;
          $display("FAIL hit_mask got %b exp %b at %0t", hit_mask, e.hit, $time);
        end
        if (miss_mask !== e.miss) begin
          n_fail++;
          $display("FAIL miss_mask got %b exp %b at %0t", miss_mask, e.miss, $time);
        end
      end
    end
  end

  initial begin
    int k, g;
    reset = 1'b1; spawn_valid = 1'b1; spawn_lane = 2'd0; key = '0;
    H_cont = '0; V_cont = '0; iRed = 8'h12; iGreen = 8'h34; iBlue = 8'h56;
    repeat (3) cyc1();
    reset = 1'b0; spawn_valid = 1'b0;
    for (int n = 0; n < 6; n++) begin probe(n + 3); cyc1(); end

    // Single note in lane 2 falls to bottom 440, is hit, then a second press finds nothing.
    spawn_valid = 1'b1; spawn_lane = 2'd2; cyc1(); spawn_valid = 1'b0;
    k = 0; g = 0;
    while (!(mact[2][0] && my[2][0] + 40 == 440) && g < 2000) begin probe(k++); cyc1(); g++; end
    key[2] = 1'b1; cyc1(); key[2] = 1'b0;
    repeat (3) begin probe(k++); cyc1(); end
    key[2] = 1'b1; cyc1(); key[2] = 1'b0;
    repeat (3) begin probe(k++); cyc1(); end

    // Unpressed note scrolls out of the window and is missed.
    spawn_valid = 1'b1; spawn_lane = 2'd2; cyc1(); spawn_valid = 1'b0;
    g = 0;
    while (mact[2][0] && g < 2000) begin probe(k++); cyc1(); g++; end
    repeat (4) begin probe(k++); cyc1(); end

    // Fill lane 0; fifth request must be refused while lane 1 stays ready.
    spawn_valid = 1'b1; spawn_lane = 2'd0;
    repeat (5) cyc1();
    spawn_lane = 2'd1; spawn_valid = 1'b0; cyc1();
    spawn_lane = 2'd0; cyc1();
    g = 0;
    while ((mact[0][0] || mact[0][3]) && g < 2000) begin probe(k++); cyc1(); g++; end

    // Key edge on the tick cycle with bottom at 470: hit on pre-scroll position, no miss.
    spawn_valid = 1'b1; spawn_lane = 2'd1; cyc1(); spawn_valid = 1'b0;
    g = 0;
    while (!(mact[1][0] && my[1][0] + 40 == 470 && (cyc % 4) == 3) && g < 2000) begin
      probe(k++); cyc1(); g++;
    end
    key[1] = 1'b1; cyc1(); key[1] = 1'b0;
    repeat (8) begin probe(k++); cyc1(); end

    // Random play, including occasional mid-game resets.
    for (int n = 0; n < 3000; n++) begin
      reset       = ($urandom_range(0, 499) == 0);
      spawn_valid = ($urandom_range(0, 7) == 0);
      spawn_lane  = 2'($urandom_range(0, 3));
      for (int b = 0; b < 4; b++) if ($urandom_range(0, 15) == 0) key[b] = ~key[b];
      H_cont = 13'($urandom_range(0, 639));
      V_cont = ($urandom_range(0, 3) == 0) ? 13'sd450 : 13'($urandom_range(0, 479));
      iRed = 8'($urandom); iGreen = 8'($urandom); iBlue = 8'($urandom);
      cyc1();
    end
    reset = 1'b0; spawn_valid = 1'b0;
    repeat (2) cyc1();

    g = 0;
    while (expq.size() > 0 && g < 10) begin @(negedge clk); g++; end
    n_tests++;
    if (expq.size() != 0) begin
      n_fail++;
      $display("FAIL drain got %0d pending exp 0", expq.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
